// File: rtl/hilo_acc.sv
// rtl/hilo_acc.sv - HI/LO result register pair with partial writes, clear and 2-cycle pipelined accumulate
//
// Holds the 2*DW-bit {HI,LO} multiply/divide result pair beside the execute stage.
// Write commands commit on the accepting edge. ACC_ADD/ACC_SUB latch the operand into
// stage 1 on the accepting edge and commit on the following edge.
//
// Optional feature macro: HILO_ACC_SAT_EN
//   defined   : accumulate is signed and saturating; o_sat is a sticky overflow flag
//   undefined : accumulate wraps modulo 2^(2*DW); o_sat is tied to 0
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   i_ce     in   command valid
//   i_op     in   3-bit command (WR_BOTH, WR_HI, WR_LO, ACC_ADD, ACC_SUB, CLR, 6-7 no-op)
//   i_hi     in   HI operand / upper half of accumulate operand
//   i_lo     in   LO operand / lower half of accumulate operand
//   i_flush  in   discard pending accumulate, block acceptance this cycle
//   o_hi     out  committed HI
//   o_lo     out  committed LO
//   o_ready  out  command can be accepted this cycle
//   o_busy   out  accumulate pending in stage 1
//   o_sat    out  sticky saturation flag
module hilo_acc #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_ce,
    input  logic [2:0]    i_op,
    input  logic [DW-1:0] i_hi,
    input  logic [DW-1:0] i_lo,
    input  logic          i_flush,
    output logic [DW-1:0] o_hi,
    output logic [DW-1:0] o_lo,
    output logic          o_ready,
    output logic          o_busy,
    output logic          o_sat
);

    localparam int AW = 2 * DW;

    localparam logic [2:0] OP_WR_BOTH = 3'd0;
    localparam logic [2:0] OP_WR_HI   = 3'd1;
    localparam logic [2:0] OP_WR_LO   = 3'd2;
    localparam logic [2:0] OP_ACC_ADD = 3'd3;
    localparam logic [2:0] OP_ACC_SUB = 3'd4;
    localparam logic [2:0] OP_CLR     = 3'd5;

    // committed register pair
    logic [DW-1:0] hi_q, hi_d;
    logic [DW-1:0] lo_q, lo_d;

    // accumulate stage 1
    logic          pend_q, pend_d;
    logic          sub_q,  sub_d;
    logic [AW-1:0] opnd_q, opnd_d;

    logic          accept;
    logic          sat_clr;
    logic          sat_set;
    logic [AW-1:0] cur;
    logic [AW-1:0] raw;
    logic [AW-1:0] acc_res;

    assign accept = i_ce & ~pend_q & ~i_flush;
    assign cur    = {hi_q, lo_q};

    // The accumulate reads the committed pair at the commit edge, so a write accepted
    // just before the accumulate is already folded into cur.
    assign raw = sub_q ? (cur - opnd_q) : (cur + opnd_q);

`ifdef HILO_ACC_SAT_EN
    logic          ovf;
    logic [AW-1:0] clamp;
    logic          sat_q, sat_d;

    // Signed overflow: effective operand sign (inverted for subtract) matches the
    // accumulator sign, but the result sign differs from it.
    assign ovf     = (cur[AW-1] == (opnd_q[AW-1] ^ sub_q)) && (raw[AW-1] != cur[AW-1]);
    // Overflow direction follows the accumulator sign: negative clamps to the minimum.
    assign clamp   = cur[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    assign acc_res = ovf ? clamp : raw;
    assign sat_set = pend_q & ~i_flush & ovf;

    always_comb begin
        sat_d = sat_q;
        if (sat_clr) begin
            sat_d = 1'b0;
        end else if (sat_set) begin
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign o_sat = sat_q;
`else
    assign acc_res = raw;
    assign sat_set = 1'b0;
    assign o_sat   = 1'b0;
`endif

    // next-state logic
    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        pend_d  = pend_q;
        sub_d   = sub_q;
        opnd_d  = opnd_q;
        sat_clr = 1'b0;

        if (pend_q) begin
            // Stage 1 always drains this edge; a flush only suppresses the commit.
            pend_d = 1'b0;
            if (!i_flush) begin
                {hi_d, lo_d} = acc_res;
            end
        end else if (accept) begin
            case (i_op)
                OP_WR_BOTH: begin
                    hi_d = i_hi;
                    lo_d = i_lo;
                end
                OP_WR_HI: begin
                    hi_d = i_hi;
                end
                OP_WR_LO: begin
                    lo_d = i_lo;
                end
                OP_ACC_ADD, OP_ACC_SUB: begin
                    pend_d = 1'b1;
                    sub_d  = (i_op == OP_ACC_SUB);
                    opnd_d = {i_hi, i_lo};
                end
                OP_CLR: begin
                    hi_d    = '0;
                    lo_d    = '0;
                    sat_clr = 1'b1;
                end
                default: begin
                    // reserved opcodes: no state change
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            pend_q <= 1'b0;
            sub_q  <= 1'b0;
            opnd_q <= '0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            pend_q <= pend_d;
            sub_q  <= sub_d;
            opnd_q <= opnd_d;
        end
    end

    assign o_hi    = hi_q;
    assign o_lo    = lo_q;
    assign o_ready = ~pend_q;
    assign o_busy  = pend_q;

endmodule

// File: tb/tb_hilo_acc.sv
// tb/tb_hilo_acc.sv - self-checking bench for hilo_acc with directed and random commands
module tb_hilo_acc;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_ce;
    logic [2:0]    i_op;
    logic [DW-1:0] i_hi;
    logic [DW-1:0] i_lo;
    logic          i_flush;
    logic [DW-1:0] o_hi;
    logic [DW-1:0] o_lo;
    logic          o_ready;
    logic          o_busy;
    logic          o_sat;

    int total = 0;
    int bad   = 0;

    // reference state
    logic [63:0] m;
    logic        msat;

    hilo_acc #(.DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_ce    (i_ce),
        .i_op    (i_op),
        .i_hi    (i_hi),
        .i_lo    (i_lo),
        .i_flush (i_flush),
        .o_hi    (o_hi),
        .o_lo    (o_lo),
        .o_ready (o_ready),
        .o_busy  (o_busy),
        .o_sat   (o_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accumulate reference: exact integer arithmetic, then either wrap or clamp.
    task automatic ref_acc(input logic [63:0] opnd, input bit sub);
`ifdef HILO_ACC_SAT_EN
        logic signed [64:0] smax;
        logic signed [64:0] smin;
        logic signed [64:0] r;
        smax = 65'sh0_7FFF_FFFF_FFFF_FFFF;
        smin = -smax - 65'sd1;
        r = sub ? ($signed({m[63], m}) - $signed({opnd[63], opnd}))
                : ($signed({m[63], m}) + $signed({opnd[63], opnd}));
        if (r > smax) begin
            m = smax[63:0];
            msat = 1'b1;
        end else if (r < smin) begin
            m = smin[63:0];
            msat = 1'b1;
        end else begin
            m = r[63:0];
        end
`else
        m = sub ? (m - opnd) : (m + opnd);
`endif
    endtask

    task automatic ref_write(input logic [2:0] op, input logic [31:0] hi, input logic [31:0] lo);
        case (op)
            3'd0: m = {hi, lo};
            3'd1: m[63:32] = hi;
            3'd2: m[31:0] = lo;
            3'd5: begin
                m = 64'd0;
                msat = 1'b0;
            end
            default: ;
        endcase
    endtask

    // Present a command for one edge; returns at the following negedge.
    task automatic step(input logic [2:0] op, input logic [31:0] hi, input logic [31:0] lo);
        i_ce = 1'b1;
        i_op = op;
        i_hi = hi;
        i_lo = lo;
        @(negedge clk);
        i_ce = 1'b0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".hi"},  {32'd0, o_hi}, {32'd0, m[63:32]});
        chk({tag, ".lo"},  {32'd0, o_lo}, {32'd0, m[31:0]});
        chk({tag, ".sat"}, {63'd0, o_sat}, {63'd0, msat});
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] rhi;
        logic [31:0] rlo;
        bit          rfl;

        rst = 1'b0; i_ce = 1'b0; i_op = 3'd0; i_hi = '0; i_lo = '0; i_flush = 1'b0;
        m = 64'd0; msat = 1'b0;

        // reset state
        #12;
        chk("rst.hi",    {32'd0, o_hi}, 64'd0);
        chk("rst.lo",    {32'd0, o_lo}, 64'd0);
        chk("rst.ready", {63'd0, o_ready}, 64'd1);
        chk("rst.busy",  {63'd0, o_busy}, 64'd0);
        chk("rst.sat",   {63'd0, o_sat}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // plain writes
        step(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        chk("wrb.hi", {32'd0, o_hi}, 64'h1234_5678);
        chk("wrb.lo", {32'd0, o_lo}, 64'h9ABC_DEF0);
        chk("wrb.ready", {63'd0, o_ready}, 64'd1);
        step(3'd1, 32'hAAAA_AAAA, 32'h0);
        chk("wrhi.hi", {32'd0, o_hi}, 64'hAAAA_AAAA);
        chk("wrhi.lo", {32'd0, o_lo}, 64'h9ABC_DEF0);
        step(3'd2, 32'h0, 32'h5555_5555);
        chk("wrlo.hi", {32'd0, o_hi}, 64'hAAAA_AAAA);
        chk("wrlo.lo", {32'd0, o_lo}, 64'h5555_5555);
        m = 64'hAAAA_AAAA_5555_5555;

        // carry from LO into HI
        step(3'd0, 32'h0, 32'hFFFF_FFFF);
        step(3'd3, 32'h0, 32'h1);
        chk("add.busy",  {63'd0, o_busy}, 64'd1);
        chk("add.ready", {63'd0, o_ready}, 64'd0);
        @(negedge clk);
        chk("add.busy2", {63'd0, o_busy}, 64'd0);
        chk("add.hi", {32'd0, o_hi}, 64'h1);
        chk("add.lo", {32'd0, o_lo}, 64'h0);
        m = 64'h1_0000_0000;

        // subtract below zero, then the most-negative boundary
        step(3'd5, 32'h0, 32'h0);
        ref_write(3'd5, 32'h0, 32'h0);
        chk_state("clr");
        step(3'd4, 32'h0, 32'h1);
        @(negedge clk);
        ref_acc(64'd1, 1'b1);
        chk("sub.hi", {32'd0, o_hi}, 64'hFFFF_FFFF);
        chk("sub.lo", {32'd0, o_lo}, 64'hFFFF_FFFF);
        chk_state("sub");
        step(3'd0, 32'h8000_0000, 32'h0);
        ref_write(3'd0, 32'h8000_0000, 32'h0);
        step(3'd4, 32'h0, 32'h1);
        @(negedge clk);
        ref_acc(64'd1, 1'b1);
        chk_state("minsub");
        step(3'd5, 32'h0, 32'h0);
        ref_write(3'd5, 32'h0, 32'h0);
        chk_state("clr2");

        // flush cancels the pending accumulate
        step(3'd0, 32'h0000_0010, 32'h0000_0020);
        ref_write(3'd0, 32'h0000_0010, 32'h0000_0020);
        step(3'd3, 32'h1, 32'h1);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        chk("flush.ready", {63'd0, o_ready}, 64'd1);
        chk_state("flush");

        // flush with i_ce accepts nothing
        i_flush = 1'b1;
        step(3'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        i_flush = 1'b0;
        chk_state("flushce");

        // write held during busy is ignored, then accepted once ready
        step(3'd3, 32'h0, 32'h5);
        i_ce = 1'b1; i_op = 3'd0; i_hi = 32'hCAFE_0001; i_lo = 32'hCAFE_0002;
        @(negedge clk);
        ref_acc(64'd5, 1'b0);
        chk("hold.ready", {63'd0, o_ready}, 64'd1);
        chk_state("hold1");
        @(negedge clk);
        i_ce = 1'b0;
        ref_write(3'd0, 32'hCAFE_0001, 32'hCAFE_0002);
        chk_state("hold2");

        // asynchronous reset mid-accumulate
        step(3'd3, 32'h0, 32'h7);
        #2 rst = 1'b0;
        #1;
        chk("arst.hi",   {32'd0, o_hi}, 64'd0);
        chk("arst.lo",   {32'd0, o_lo}, 64'd0);
        chk("arst.busy", {63'd0, o_busy}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        m = 64'd0; msat = 1'b0;
        @(negedge clk);
        chk_state("arst.post");
        chk("arst.busy2", {63'd0, o_busy}, 64'd0);

        // random commands with occasional flush of accumulates
        for (int i = 0; i < 80; i++) begin
            rop = 3'($urandom_range(0, 7));
            rhi = $urandom;
            rlo = $urandom;
            if ($urandom_range(0, 3) == 0) rhi = {rhi[31], 31'h7FFF_FFFF};
            rfl = ($urandom_range(0, 3) == 0);
            step(rop, rhi, rlo);
            if (rop == 3'd3 || rop == 3'd4) begin
                chk("rnd.busy", {63'd0, o_busy}, 64'd1);
                i_flush = rfl;
                @(negedge clk);
                i_flush = 1'b0;
                if (!rfl) ref_acc({rhi, rlo}, rop == 3'd4);
            end else begin
                ref_write(rop, rhi, rlo);
            end
            chk("rnd.ready", {63'd0, o_ready}, 64'd1);
            chk_state("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
